button_debounce: RTL and testbench
==================================

# button_debounce

Debounces a raw push-button or switch input into a clean, registered level. The block first synchronises the input into `clk`, then only accepts a new level after it has held steady for a programmable number of cycles. It sits directly upstream of `one_pulse`: the `out` level drives the `in` port of `one_pulse`, which then issues a single-cycle strobe per press. An optional long-press detector is also provided.

## Interface
- `STABLE_CYCLES`, 16: consecutive cycles the synchronised input must differ from `out` before `out` flips; legal range ≥ 2.
- `LONG_CYCLES`, 1000: cycles `out` must stay high before `long_press` fires; legal range > `STABLE_CYCLES`. Used only with the macro.
- `CNT_W`, 16: counter width; must satisfy 2^`CNT_W` > max(`STABLE_CYCLES`, `LONG_CYCLES`).
- `clk` in 1: single system clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset; the codebase's reset with an active-low suffix.
- `en` in 1: filter enable.
- `in` in 1: raw, asynchronous, bouncy input.
- `out` out 1: debounced level, registered.
- `changed` out 1: one-cycle pulse, registered, on every `out` transition.
- `long_press` out 1: one-cycle pulse, registered. Present only with the macro.

## Operation
- Synchroniser: two flops, `in` → `s1` → `s2`. They run regardless of `en`. Reset value is 0.
- FSM states:
  - `LO`: `out`=0.
  - `CHK_HI`: `out`=0, counting.
  - `HI`: `out`=1.
  - `CHK_LO`: `out`=1, counting.
  - Reset state is `LO`, with `cnt`=0.
- `LO` → `CHK_HI` when `s2`=1; `cnt` is set to 1.
- `CHK_HI`:
  - If `s2`=0: return to `LO` and set `cnt`=0. A glitch is discarded.
  - Else if `cnt`=`STABLE_CYCLES`-1: go to `HI`, set `out`=1, `changed`=1, `cnt`=0.
  - Else increment `cnt`.
- `HI` / `CHK_LO`: mirror image of the above, triggered by `s2`=0. The exit sets `out`=0 and `changed`=1.
- `en`=0:
  - The FSM is forced to the stable state matching the current `out` (`LO` or `HI`).
  - `cnt`=0, `out` holds, `changed`=0, `long_press`=0.
  - Filtering restarts from zero when `en` returns to 1.
- Counter arithmetic: `cnt` is unsigned `CNT_W` bits and never wraps. Its maximum is `STABLE_CYCLES`-1.

## Timing
- Reset values: `out`=0, `changed`=0, `long_press`=0, `s1`=`s2`=0, `cnt`=0, `hold_cnt`=0.
- Latency for a clean step on `in` arriving before edge E0:
  - `s2` changes after edge E1.
  - `out` and `changed` update after edge E(`STABLE_CYCLES`+1).
  - Total: `STABLE_CYCLES`+2 edges.
- Glitch rejection: any `s2` excursion shorter than `STABLE_CYCLES` cycles produces no change on `out`.
- Bounce during `CHK_*`: the counter restarts from 0 on the first cycle `s2` equals `out`. There is no partial credit.
- `changed` is high for exactly one cycle, coincident with the first cycle of the new `out` value.
- If `s2` toggles in the same edge that `en` falls: `en` has priority.
- Asynchronous `reset_n` assertion mid-count:
  - All outputs go to 0 immediately.
  - There is no pulse on `changed` after release.
  - The first post-reset `out` rise needs the full `STABLE_CYCLES`+2 cycles.

## Configuration
- Macro: `BUTTON_DEBOUNCE_LONG_PRESS_EN`.
- When defined:
  - A `CNT_W`-bit `hold_cnt` clears on entry to `HI`.
  - It increments each cycle in `HI` or `CHK_LO` while `en`=1, saturating at `LONG_CYCLES`.
  - `long_press` pulses for one cycle on the edge where `hold_cnt` reaches `LONG_CYCLES`, i.e. `LONG_CYCLES` cycles after `out` rose.
  - It fires at most once per press.
  - `en`=0 or `out` falling clears `hold_cnt`.
- When undefined: the `long_press` port, `hold_cnt` and `LONG_CYCLES` logic are absent.

## Test plan
- Reset: assert `reset_n`=0 with `in`=1, then release.
  - Required: `out`=0 and `changed`=0 throughout reset.
  - Required: `out`=1 exactly `STABLE_CYCLES`+2 edges after release. With `STABLE_CYCLES`=4, that is 6 edges.
- Clean press and release, `STABLE_CYCLES`=4: `in` rises, held 20 cycles, then falls.
  - Required: `out` rises 6 edges after `in` rises, `changed`=1 for that one cycle.
  - Required: `out` falls 6 edges after `in` falls, with one more `changed` pulse.
- Bounce, `STABLE_CYCLES`=4: `in` high 3 cycles, low 1 cycle, then high 10 cycles.
  - Required: no `out` change from the 3-cycle pulse.
  - Required: `out` rises 6 edges after the final rise, and there is exactly one `changed` pulse in total.
- Enable gating: `en`=0 while `in` goes high for 50 cycles, then `en`=1.
  - Required: `out` stays 0 and `changed` stays 0 while `en`=0.
  - Required: `out` rises `STABLE_CYCLES` edges after `en` rises.
- Long press, macro defined, `LONG_CYCLES`=10: hold `in` high 40 cycles.
  - Required: `long_press` is high for exactly one cycle, 10 cycles after `out` rose, and never again in that press.
- Reset mid-count: drop `reset_n` while in `CHK_HI` with `cnt`=2.
  - Required: `out` and `changed` stay 0.
  - Required: after release with `in` still high, `out` rises only after the full 6 edges.

Source files
------------

// File: rtl/button_debounce.sv
// Debounces a raw button input: two-flop synchroniser followed by a stability filter FSM.
// Optional long-press pulse is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
    parameter int STABLE_CYCLES = 16,
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    parameter int LONG_CYCLES   = 1000,
`endif
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic in,
    output logic out,
    output logic changed
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_r, state_s;
    logic             s1_r, s2_r;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             out_r, out_s;
    logic             changed_r, changed_s;

    // Two-flop synchroniser, free-running regardless of en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= in;
            s2_r <= s1_r;
        end
    end

    // Filter next-state: any sample agreeing with out drops back to the stable state
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        out_s     = out_r;
        changed_s = 1'b0;
        if (!en) begin
            state_s = out_r ? HI : LO;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                LO: begin
                    if (s2_r) begin
                        state_s = CHK_HI;
                        cnt_s   = CNT_ONE;
                    end else begin
                        state_s = LO;
                        cnt_s   = CNT_ZERO;
                    end
                end
                CHK_HI: begin
                    if (!s2_r) begin
                        state_s = LO;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s   = HI;
                        cnt_s     = CNT_ZERO;
                        out_s     = 1'b1;
                        changed_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                HI: begin
                    if (!s2_r) begin
                        state_s = CHK_LO;
                        cnt_s   = CNT_ONE;
                    end else begin
                        state_s = HI;
                        cnt_s   = CNT_ZERO;
                    end
                end
                CHK_LO: begin
                    if (s2_r) begin
                        state_s = HI;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s   = LO;
                        cnt_s     = CNT_ZERO;
                        out_s     = 1'b0;
                        changed_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = LO;
                    cnt_s   = CNT_ZERO;
                    out_s   = 1'b0;
                end
            endcase
        end
    end

    // Filter state, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= LO;
            cnt_r     <= CNT_ZERO;
            out_r     <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            out_r     <= out_s;
            changed_r <= changed_s;
        end
    end

    assign out     = out_r;
    assign changed = changed_r;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic             long_press_r, long_press_s;

    // Hold counter saturates so the pulse fires once; only an out edge or en=0 re-arms it
    always_comb begin
        hold_cnt_s   = hold_cnt_r;
        long_press_s = 1'b0;
        if (!en) begin
            hold_cnt_s = CNT_ZERO;
        end else if (changed_s) begin
            hold_cnt_s = CNT_ZERO;
        end else if ((state_r == HI) || (state_r == CHK_LO)) begin
            if (hold_cnt_r != HOLD_MAX) begin
                hold_cnt_s   = hold_cnt_r + CNT_ONE;
                long_press_s = (hold_cnt_r == (HOLD_MAX - CNT_ONE));
            end else begin
                hold_cnt_s = hold_cnt_r;
            end
        end else begin
            hold_cnt_s = hold_cnt_r;
        end
    end

    // Long-press counter and registered pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_r   <= CNT_ZERO;
            long_press_r <= 1'b0;
        end else begin
            hold_cnt_r   <= hold_cnt_s;
            long_press_r <= long_press_s;
        end
    end

    assign long_press = long_press_r;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed vector table, hand-written reset
// sequences and randomised bouncy input checked against a run-length reference model.
module tb_button_debounce;

    localparam int S = 4;
    localparam int L = 10;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic in;
    logic out;
    logic changed;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    logic long_press;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES(S),
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        .LONG_CYCLES(L),
`endif
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .in(in),
        .out(out),
        .changed(changed)
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        ,
        .long_press(long_press)
`endif
    );

    // Reference model: out flips after S consecutive enabled samples that disagree with it
    logic m_s1, m_s2, m_out, m_changed, m_lp;
    int   m_run, m_held;

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_changed = 1'b0; m_lp = 1'b0;
        m_run = 0; m_held = 0;
    endtask

    task automatic model_edge(input logic e, input logic i);
        logic s2_pre;
        s2_pre    = m_s2;
        m_s2      = m_s1;
        m_s1      = i;
        m_changed = 1'b0;
        m_lp      = 1'b0;
        if (!e) begin
            m_run  = 0;
            m_held = 0;
        end else begin
            if (s2_pre != m_out) m_run++;
            else                 m_run = 0;
            if (m_run == S) begin
                m_out     = ~m_out;
                m_changed = 1'b1;
                m_run     = 0;
                m_held    = 0;
            end else if (m_out && (m_held < L)) begin
                m_held++;
                m_lp = (m_held == L);
            end
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit
    task automatic tick(input logic e, input logic i);
        en = e;
        in = i;
        @(posedge clk);
        if (reset_n) model_edge(e, i);
        else         model_reset();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_out"}, out, m_out);
        check({tag, "_changed"}, changed, m_changed);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        check({tag, "_long_press"}, long_press, m_lp);
`endif
    endtask

    typedef struct {
        logic en;
        logic in;
        int   reps;
        logic exp_out;
        logic exp_changed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic i, input int r, input logic o, input logic c);
        vec_t v;
        v.en = e; v.in = i; v.reps = r; v.exp_out = o; v.exp_changed = c;
        tbl.push_back(v);
    endtask

    initial begin
        int runleft;
        logic cur;
        int lp_count;

        reset_n = 1'b0;
        en      = 1'b1;
        in      = 1'b1;
        model_reset();

        // Reset held with in=1: outputs stay low, then a full-latency rise after release
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            check("rst_hold_out", out, 1'b0);
            check("rst_hold_changed", changed, 1'b0);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b1);
            check("rst_rel_out", out, (k == 6));
            check("rst_rel_changed", changed, (k == 6));
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
        check("settle_out", out, 1'b0);

        // Clean press/release, bounce, en priority, enable gating
        add(1, 1, 5, 0, 0); add(1, 1, 1, 1, 1); add(1, 1, 14, 1, 0);
        add(1, 0, 5, 1, 0); add(1, 0, 1, 0, 1); add(1, 0, 4, 0, 0);
        add(1, 1, 3, 0, 0); add(1, 0, 1, 0, 0); add(1, 1, 5, 0, 0);
        add(1, 1, 1, 1, 1); add(1, 1, 4, 1, 0);
        add(1, 0, 5, 1, 0); add(1, 0, 1, 0, 1); add(1, 0, 2, 0, 0);
        add(1, 1, 5, 0, 0); add(0, 1, 1, 0, 0); add(1, 1, 3, 0, 0);
        add(1, 1, 1, 1, 1); add(1, 1, 2, 1, 0);
        add(1, 0, 5, 1, 0); add(1, 0, 1, 0, 1); add(1, 0, 2, 0, 0);
        add(0, 1, 50, 0, 0); add(1, 1, 3, 0, 0); add(1, 1, 1, 1, 1);
        add(1, 1, 3, 1, 0); add(0, 0, 5, 1, 0); add(1, 0, 3, 1, 0);
        add(1, 0, 1, 0, 1); add(1, 0, 2, 0, 0);

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                tick(tbl[k].en, tbl[k].in);
                check($sformatf("vec%0d_out", k), out, tbl[k].exp_out);
                check($sformatf("vec%0d_changed", k), changed, tbl[k].exp_changed);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
                check($sformatf("vec%0d_long_press", k), long_press, m_lp);
`endif
            end
        end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        // Long press: out rises at step 5, single pulse L cycles later
        lp_count = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b1);
            check("lp_out", out, (k >= 5));
            check("lp_pulse", long_press, (k == 5 + L));
            if (long_press) lp_count++;
        end
        check("lp_once", (lp_count == 1), 1'b1);
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0);
`else
        lp_count = 0;
`endif

        // Reset mid-count (CHK_HI, cnt=2) then full latency after release
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1);
            check("mid_pre_out", out, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out", out, 1'b0);
        check("mid_rst_changed", changed, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b1);
            check("mid_rel_out", out, (k == 6));
            check("mid_rel_changed", changed, (k == 6));
        end

        // Asynchronous clear while out=1, and no changed pulse after release
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out", out, 1'b0);
        check("async_changed", changed, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0);
            check("post_rst_out", out, 1'b0);
            check("post_rst_changed", changed, 1'b0);
        end

        // Randomised bouncy input with occasional long holds and enable drops
        cur     = 1'b0;
        runleft = 0;
        for (int k = 0; k < 3000; k++) begin
            if (runleft == 0) begin
                cur     = ~cur;
                runleft = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                      : $urandom_range(1, 6);
            end
            runleft--;
            tick(($urandom_range(0, 19) != 0), cur);
            cmp_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
